bus_wr_arbiter: RTL and testbench
=================================

Name: bus_wr_arbiter

Overview:
- Round-robin arbiter that shares one downstream write bus (wvalid/wready/waddr/wdata) between N upstream write requesters.
- Each upstream port and the downstream port use the same valid/ready write handshake as the bus_master/bus_slave models.
- Sits between several bus masters (e.g. DMA, CPU config port) and a single register/memory slave.
- The grant is locked for exactly one transfer, then the bus is re-arbitrated.

Parameters:
- N, 4, number of requesters (2..16).
- BAW, 32, address width.
- BDW, 32, data width.
- IW, $clog2(N), grant index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- s_wvalid  in  N  per-requester write valid.
- s_wready  out  N  per-requester write ready.
- s_waddr  in  N*BAW  requester addresses; requester i occupies bits [i*BAW +: BAW].
- s_wdata  in  N*BDW  requester data; requester i occupies bits [i*BDW +: BDW].
- m_wvalid  out  1  downstream write valid.
- m_wready  in  1  downstream write ready.
- m_waddr  out  BAW  downstream address.
- m_wdata  out  BDW  downstream data.
- grant  out  N  one-hot registered grant; all zero when idle.
- grant_id  out  IW  index of the granted requester; 0 when idle.

Behaviour:
- State machine states: IDLE, BUSY.
- Registers:
  - state.
  - grant (one-hot).
  - grant_id.
  - last: index of the most recent winner.
- Reset values (the next posedge with rst=1 forces all of these):
  - state=IDLE.
  - grant=0.
  - grant_id=0.
  - last=N-1, so requester 0 has highest priority after reset.
  - rst overrides every other event, including a handshake in the same cycle.
- IDLE:
  - If no s_wvalid bit is set, stay in IDLE.
  - Otherwise pick the first set s_wvalid bit, searching from index last+1 upward and wrapping modulo N.
  - Register grant/grant_id for the winner and go to BUSY.
  - Exactly one grant at a time; the search wraps correctly for any N, including non-powers of 2.
- BUSY (combinational muxing from the registered grant_id):
  - m_wvalid = s_wvalid[grant_id].
  - m_waddr/m_wdata = the granted requester's slice.
  - s_wready[grant_id] = m_wready; all other s_wready bits are 0.
  - Handshake when m_wvalid & m_wready at posedge. On that edge:
    - last <= grant_id.
    - grant <= 0.
    - state <= IDLE.
  - Without a handshake, stay in BUSY and hold the grant. This holds even if the granted requester deasserts s_wvalid, so no other requester is served until the handshake completes.
- IDLE outputs:
  - m_wvalid=0.
  - m_waddr=0.
  - m_wdata=0 (never X).
  - s_wready=0.
- Latency and throughput:
  - One idle arbitration cycle precedes each transfer.
  - The earliest handshake is the 2nd posedge after s_wvalid rises, given m_wready=1.
  - Peak throughput is one transfer per 2 cycles.
- Simultaneous requests: round-robin ordering guarantees each continuously requesting port is served within N transfers.
- A request arriving while BUSY is only seen at the next IDLE evaluation.
- s_wvalid of non-granted requesters never reaches m_wvalid.
- Reset mid-transfer:
  - The grant is dropped after the reset edge and m_wvalid falls to 0.
  - The upstream transfer is abandoned; the requester must retry.

Test Plan:
- Single request: after reset, req 2 drives valid with addr 0x10, data 0xA5 and m_wready=1 -> grant=4'b0100 after 1st edge; m_waddr=0x10 and m_wdata=0xA5 while BUSY; s_wready[2]=1 only; handshake on 2nd edge; back to IDLE with grant=0.
- All four request continuously with m_wready=1 -> service order 0,1,2,3,0,... with one transfer every 2 cycles; grant always one-hot.
- Backpressure: req 1 granted with m_wready=0 for 5 cycles -> grant and m_waddr/m_wdata held stable; s_wready[1]=0; req 3 valid is ignored; m_wready=1 -> handshake, then req 3 is granted next.
- Wrap-around: last=3 with reqs 0 and 2 valid -> req 0 wins; then req 2.
- Reset mid-transfer: rst=1 while BUSY with m_wready=0 -> after that edge grant=0 and m_wvalid=0; after release req 0 wins first (last=N-1).
- Idle bus: no valids for 10 cycles -> m_wvalid=0, m_waddr=0, m_wdata=0, s_wready=0, grant=0, grant_id=0 throughout.

Source files
------------

// File: rtl/bus_wr_arbiter.sv
// Round-robin arbiter sharing one downstream valid/ready write bus between N requesters.
// Each grant covers exactly one transfer; an idle cycle re-arbitrates before the next.
module bus_wr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned BAW = 32,
  parameter int unsigned BDW = 32,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s_wvalid,
  output logic [N-1:0]     s_wready,
  input  logic [N*BAW-1:0] s_waddr,
  input  logic [N*BDW-1:0] s_wdata,
  output logic             m_wvalid,
  input  logic             m_wready,
  output logic [BAW-1:0]   m_waddr,
  output logic [BDW-1:0]   m_wdata,
  output logic [N-1:0]     grant,
  output logic [IW-1:0]    grant_id
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [IW-1:0]   last_q, last_d;

  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   cand;
  logic            handshake;

  // Search starts just past the previous winner and wraps modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(last_q) + 32'd1 + k) % N);
      if (!win_found && s_wvalid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    m_wvalid = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    s_wready = '0;
    if (state_q == StBusy) begin
      m_wvalid = |(s_wvalid & grant_q);
      s_wready = grant_q & {N{m_wready}};
      for (int unsigned i = 0; i < N; i++) begin
        if (grant_q[i]) begin
          m_waddr = s_waddr[i*BAW +: BAW];
          m_wdata = s_wdata[i*BDW +: BDW];
        end
      end
    end
  end

  assign handshake = (state_q == StBusy) && m_wvalid && m_wready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d         = StBusy;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          grant_id_d      = win_id;
        end
      end
      StBusy: begin
        // Grant is held until the handshake, even if the owner drops valid.
        if (handshake) begin
          state_d    = StIdle;
          grant_d    = '0;
          grant_id_d = '0;
          last_d     = grant_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= IW'(N - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_bus_wr_arbiter.sv
// Bench for bus_wr_arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against a transaction-level round-robin model.
module tb_bus_wr_arbiter;
  localparam int N   = 4;
  localparam int BAW = 32;
  localparam int BDW = 32;
  localparam int IW  = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     s_wvalid = '0;
  logic [N-1:0]     s_wready;
  logic [N*BAW-1:0] s_waddr = '0;
  logic [N*BDW-1:0] s_wdata = '0;
  logic             m_wvalid;
  logic             m_wready = 1'b0;
  logic [BAW-1:0]   m_waddr;
  logic [BDW-1:0]   m_wdata;
  logic [N-1:0]     grant;
  logic [IW-1:0]    grant_id;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: is the bus owned, by whom, and who was served last.
  bit busy = 1'b0;
  int owner = 0;
  int last_won = N - 1;
  int model_served[$];
  int dut_served[$];

  bus_wr_arbiter #(.N(N), .BAW(BAW), .BDW(BDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_waddr  (s_waddr),
    .s_wdata  (s_wdata),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_waddr  (m_waddr),
    .m_wdata  (m_wdata),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  function automatic int pick(int lst, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (lst + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [63:0] pack(int q[$]);
    logic [63:0] val;
    val = '0;
    foreach (q[i]) val = (val << 4) | 64'(q[i]);
    return val;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      busy     = 1'b0;
      owner    = 0;
      last_won = N - 1;
    end else if (!busy) begin
      if (s_wvalid != '0) begin
        owner = pick(last_won, s_wvalid);
        busy  = 1'b1;
      end
    end else if (s_wvalid[owner] && m_wready) begin
      model_served.push_back(owner);
      last_won = owner;
      busy     = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]   e_grant;
      logic [N-1:0]   e_rdy;
      logic [BAW-1:0] e_addr;
      logic [BDW-1:0] e_data;
      logic           e_valid;
      int             e_id;
      e_grant = '0;
      e_rdy   = '0;
      e_addr  = '0;
      e_data  = '0;
      e_valid = 1'b0;
      e_id    = 0;
      if (busy) begin
        e_grant[owner] = 1'b1;
        e_rdy[owner]   = m_wready;
        e_id           = owner;
        e_valid        = s_wvalid[owner];
        e_addr         = s_waddr[owner*BAW +: BAW];
        e_data         = s_wdata[owner*BDW +: BDW];
      end
      check("grant", 64'(grant), 64'(e_grant));
      check("grant_id", 64'(grant_id), 64'(e_id));
      check("m_wvalid", 64'(m_wvalid), 64'(e_valid));
      check("m_waddr", 64'(m_waddr), 64'(e_addr));
      check("m_wdata", 64'(m_wdata), 64'(e_data));
      check("s_wready", 64'(s_wready), 64'(e_rdy));
      if (m_wvalid && m_wready && !rst) dut_served.push_back(int'(grant_id));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_wvalid = '0;
    m_wready = 1'b0;
    step();
    chk_en   = 1'b1;
    rst      = 1'b0;
    model_served.delete();
    dut_served.delete();
  endtask

  initial begin
    // Single request from requester 2
    do_reset();
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_grant_id", 64'(grant_id), 64'h0);
    check("rst_m_wvalid", 64'(m_wvalid), 64'h0);
    s_waddr[2*BAW +: BAW] = 32'h10;
    s_wdata[2*BDW +: BDW] = 32'hA5;
    s_wvalid = 4'b0100;
    m_wready = 1'b1;
    step();
    @(negedge clk);
    check("single_grant", 64'(grant), 64'b0100);
    check("single_addr", 64'(m_waddr), 64'h10);
    check("single_data", 64'(m_wdata), 64'hA5);
    check("single_rdy", 64'(s_wready), 64'b0100);
    step();
    s_wvalid = '0;
    @(negedge clk);
    check("single_done", 64'(grant), 64'h0);
    check("single_order", pack(dut_served), 64'h2);

    // All four requesting continuously
    do_reset();
    s_wvalid = 4'b1111;
    m_wready = 1'b1;
    repeat (16) step();
    s_wvalid = '0;
    check("rr_count", 64'(dut_served.size()), 64'd8);
    check("rr_order", pack(dut_served), 64'h01230123);
    check("rr_model", pack(model_served), 64'h01230123);

    // Backpressure: req 1 held, req 3 must wait
    do_reset();
    s_waddr[1*BAW +: BAW] = 32'h44;
    s_wdata[1*BDW +: BDW] = 32'h55;
    s_wvalid = 4'b0010;
    step();
    s_wvalid = 4'b1010;
    repeat (5) begin
      @(negedge clk);
      check("bp_grant", 64'(grant), 64'b0010);
      check("bp_addr", 64'(m_waddr), 64'h44);
      check("bp_rdy", 64'(s_wready), 64'h0);
      step();
    end
    m_wready = 1'b1;
    step();
    s_wvalid = 4'b1000;
    step();
    step();
    s_wvalid = '0;
    check("bp_order", pack(dut_served), 64'h13);

    // Wrap-around from last=3
    do_reset();
    m_wready = 1'b1;
    s_wvalid = 4'b1000;
    step();
    step();
    s_wvalid = 4'b0101;
    repeat (4) step();
    s_wvalid = '0;
    check("wrap_count", 64'(dut_served.size()), 64'd3);
    check("wrap_order", pack(dut_served), 64'h302);

    // Reset while busy
    do_reset();
    s_wvalid = 4'b0100;
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_grant", 64'(grant), 64'h0);
    check("mid_rst_valid", 64'(m_wvalid), 64'h0);
    rst      = 1'b0;
    s_wvalid = 4'b0101;
    m_wready = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_winner", 64'(grant), 64'b0001);
    step();
    s_wvalid = '0;

    // Idle bus with garbage on address/data
    step();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        s_waddr[i*BAW +: BAW] = $urandom;
        s_wdata[i*BDW +: BDW] = $urandom;
      end
      @(negedge clk);
      check("idle_out", {m_wvalid, m_waddr, m_wdata[15:0], grant, grant_id, s_wready}, 64'h0);
      step();
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      s_wvalid = N'($urandom);
      m_wready = ($urandom % 4) != 0;
      rst      = ($urandom % 150) == 0;
      for (int i = 0; i < N; i++) begin
        s_waddr[i*BAW +: BAW] = $urandom;
        s_wdata[i*BDW +: BDW] = $urandom;
      end
      @(negedge clk);
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL onehot: got %b required at most one bit", grant);
      end
      step();
    end
    rst = 1'b0;
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
